// File: rtl/acc_pkg.sv
// Shared types and constants for the add/sub accumulator slice.
package acc_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ADD   = 2'b00,
        SUB   = 2'b01,
        LOAD  = 2'b10,
        CLEAR = 2'b11
    } op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/add32_core.sv
// Combinational carry-lookahead adder: 4-bit lookahead groups whose
// group carries are chained; the operands are zero-padded to a multiple of 4.
module add32_core
    import acc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NB = (WIDTH + 3) / 4;
    localparam int PW = NB * 4;

    logic [PW-1:0] a_p;
    logic [PW-1:0] b_p;
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW:0]   c;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        a_p = '0;
        b_p = '0;
        a_p[WIDTH-1:0] = a;
        b_p[WIDTH-1:0] = b;
        g = a_p & b_p;
        p = a_p ^ b_p;
        c = '0;
        c[0] = cin;
        for (int blk = 0; blk < NB; blk++) begin
            int  base;
            logic ci;
            logic grp_g;
            logic grp_p;
            base  = blk * 4;
            ci    = c[base];
            grp_g = g[base+3]
                  | (p[base+3] & g[base+2])
                  | (p[base+3] & p[base+2] & g[base+1])
                  | (p[base+3] & p[base+2] & p[base+1] & g[base]);
            grp_p = p[base+3] & p[base+2] & p[base+1] & p[base];
            c[base+1] = g[base] | (p[base] & ci);
            c[base+2] = g[base+1] | (p[base+1] & g[base]) | (p[base+1] & p[base] & ci);
            c[base+3] = g[base+2]
                      | (p[base+2] & g[base+1])
                      | (p[base+2] & p[base+1] & g[base])
                      | (p[base+2] & p[base+1] & p[base] & ci);
            c[base+4] = grp_g | (grp_p & ci);
        end
    end

    assign sum  = p[WIDTH-1:0] ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/add_sub_accumulator.sv
// Handshaked add/sub/load/clear accumulator with a one-entry result register.
// Define ADD_SUB_ACCUMULATOR_SAT_EN to saturate on signed overflow instead of wrapping.
module add_sub_accumulator
    import acc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    state_e           state_q;
    state_e           state_d;
    op_e              op;
    logic             accept;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             ovf_raw;
    logic [WIDTH-1:0] acc_d;
    logic             cout_d;
    logic             ovf_d;

    assign op        = op_e'(in_op);
    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // SUB reuses the adder as acc + ~b + 1.
    assign add_b   = (op == SUB) ? ~in_data : in_data;
    assign add_cin = (op == SUB);

    add32_core #(.WIDTH(WIDTH)) u_add (
        .a    (out_acc),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign ovf_raw = (out_acc[WIDTH-1] == add_b[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != out_acc[WIDTH-1]);

    always_comb begin
        acc_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        case (op)
            ADD, SUB: begin
                acc_d  = add_sum;
                cout_d = add_cout;
                ovf_d  = ovf_raw;
`ifdef ADD_SUB_ACCUMULATOR_SAT_EN
                // Operand sign tells the overflow direction: positive operands clamp high.
                if (ovf_raw) begin
                    acc_d = out_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
            LOAD:    acc_d = in_data;
            default: acc_d = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            out_acc  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                out_acc  <= acc_d;
                out_cout <= cout_d;
                out_ovf  <= ovf_d;
                out_zero <= (acc_d == '0);
            end
        end
    end

endmodule

// File: tb/tb_add_sub_accumulator.sv
// Directed self-checking bench for add_sub_accumulator (WIDTH = 32).
module tb_add_sub_accumulator;

    localparam int W = 32;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] data;
        logic [W-1:0] exp_acc;
        logic         exp_cout;
        logic         exp_ovf;
        logic         exp_zero;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_acc;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    int tests_run = 0;
    int tests_failed = 0;

    vec_t vecs[14];

    add_sub_accumulator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] acc,
                                input logic cout, input logic ovf, input logic zero);
        check({tag, " valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, " acc"},   64'(out_acc),   64'(acc));
        check({tag, " cout"},  64'(out_cout),  64'(cout));
        check({tag, " ovf"},   64'(out_ovf),   64'(ovf));
        check({tag, " zero"},  64'(out_zero),  64'(zero));
    endtask

    initial begin
        vecs[0]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b00, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{2'b10, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
`ifdef ADD_SUB_ACCUMULATOR_SAT_EN
        vecs[3]  = '{2'b00, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
`else
        vecs[3]  = '{2'b00, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
`endif
        vecs[4]  = '{2'b10, 32'h0000_0006, 32'h0000_0006, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'b01, 32'h0000_0003, 32'h0000_0003, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2'b01, 32'h0000_0008, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
`ifdef ADD_SUB_ACCUMULATOR_SAT_EN
        vecs[10] = '{2'b01, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
        vecs[10] = '{2'b01, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
`endif
        vecs[11] = '{2'b10, 32'h0000_000A, 32'h0000_000A, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0009, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{2'b01, 32'h0000_0009, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_op = 2'b00;
        in_data = '0;
        out_ready = 1'b1;

        // Reset with a command on the inputs; it must be discarded.
        @(negedge clk);
        in_valid = 1'b1;
        in_op = 2'b10;
        in_data = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("reset valid",    64'(out_valid), 64'(1'b0));
        check("reset acc",      64'(out_acc),   64'(0));
        check("reset zero",     64'(out_zero),  64'(1'b1));
        check("reset cout",     64'(out_cout),  64'(1'b0));
        check("reset ovf",      64'(out_ovf),   64'(1'b0));
        check("reset in_ready", 64'(in_ready),  64'(1'b1));

        // Table vectors, one command at a time, consumer always ready.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op = vecs[i].op;
            in_data = vecs[i].data;
            @(negedge clk);
            in_valid = 1'b0;
            check_result($sformatf("vec%0d", i), vecs[i].exp_acc, vecs[i].exp_cout,
                         vecs[i].exp_ovf, vecs[i].exp_zero);
        end

        // Backpressure: pending LOAD 100 held while ADD 5 waits at the input.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 2'b10;
        in_data = 32'd100;
        @(negedge clk);
        in_op = 2'b00;
        in_data = 32'd5;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d in_ready", k), 64'(in_ready), 64'(1'b0));
            check_result($sformatf("bp%0d", k), 32'd100, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(in_ready), 64'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_result("bp next", 32'd105, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_result("bp held", 32'd105, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp drained valid", 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        check("bp no duplicate", 64'(out_valid), 64'(1'b0));

        // Reset while a result is pending and stalled.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 2'b10;
        in_data = 32'd55;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid pending valid", 64'(out_valid), 64'(1'b1));
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 32'd77;
        @(negedge clk);
        check("mid reset valid", 64'(out_valid), 64'(1'b0));
        check("mid reset acc",   64'(out_acc),   64'(0));
        check("mid reset zero",  64'(out_zero),  64'(1'b1));
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid in_ready", 64'(in_ready), 64'(1'b1));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid stale%0d", k), 64'(out_valid), 64'(1'b0));
            @(negedge clk);
        end
        check("mid acc kept", 64'(out_acc), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add_sub_accumulator.md
ADD_SUB_ACCUMULATOR -- requirements
Module: add_sub_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the datapath and accumulator width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  command present.
REQ-005 SHALL have port in_ready  output  1  command accepted when high together with in_valid.
REQ-006 SHALL have port in_op  input  2  opcode: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
REQ-007 SHALL have port in_data  input  WIDTH  operand B for ADD/SUB; load value for LOAD; ignored for CLEAR.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result when high together with out_valid.
REQ-010 SHALL have port out_acc  output  WIDTH  accumulator value after the accepted command.
REQ-011 SHALL have port out_cout  output  1  adder carry-out; for SUB, 1 = no borrow.
REQ-012 SHALL have port out_ovf  output  1  two's-complement signed overflow.
REQ-013 SHALL have port out_zero  output  1  high when out_acc == 0.

Function
REQ-014 SHALL accept a command on a cycle where in_valid && in_ready.
REQ-015 SHALL drive in_ready = !out_valid || out_ready; combinational, no other inputs.
REQ-016 SHALL use a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY -> FULL on accept.
- FULL -> EMPTY on out_ready without accept.
- FULL stays FULL on out_ready with accept.
REQ-017 SHALL present each result one cycle after acceptance: accept at edge N, out_valid high from edge N+1.
REQ-018 SHALL compute ADD as acc + in_data + 0 and SUB as acc + ~in_data + 1, both through one WIDTH-bit adder.
REQ-019 SHALL set out_ovf on ADD/SUB when both adder operands have the same MSB and the sum MSB differs from it.
REQ-020 SHALL, on LOAD, set acc = in_data and out_cout = out_ovf = 0.
REQ-021 SHALL, on CLEAR, set acc = 0, out_cout = out_ovf = 0 and out_zero = 1.
REQ-022 SHALL hold out_acc, out_cout, out_ovf and out_zero stable while out_valid && !out_ready.
REQ-023 SHALL update the accumulator only on accept; a result SHALL never be dropped or duplicated.

Reset
REQ-024 SHALL, on a clock edge with rst_n == 0, set state to EMPTY and set out_valid = 0, out_acc = 0, out_cout = 0, out_ovf = 0 and out_zero = 1.
REQ-025 SHALL discard any pending result or command present during reset; in_ready SHALL read 1 in the cycle after reset releases.

Configuration
REQ-026 SHALL use the macro ADD_SUB_ACCUMULATOR_SAT_EN to select overflow handling.
- Defined: on ADD/SUB with overflow, acc saturates to 0x7FFF_FFFF (positive overflow) or 0x8000_0000 (negative overflow), scaled to WIDTH; out_ovf is still 1.
- Undefined: the result wraps modulo 2^WIDTH.

Structure
REQ-027 SHALL import package acc_pkg, which holds:
- the op_e enum (ADD, SUB, LOAD, CLEAR);
- the state_e enum (EMPTY, FULL);
- localparam DEFAULT_WIDTH = 32.
REQ-028 SHALL instantiate one combinational sub-module, add32_core (A, B, Cin -> S, Cout, carry-lookahead); the accumulator, flags and FSM SHALL stay in the top level.

Verification
REQ-029 The bench SHALL check reset: after the rst_n pulse, expect out_valid=0, out_acc=0, out_zero=1, in_ready=1.
REQ-030 The bench SHALL check carry: LOAD 0xFFFF_FFFF, then ADD 0x1 -> out_acc=0, out_cout=1, out_zero=1, out_ovf=0.
REQ-031 The bench SHALL check overflow: LOAD 0x7FFF_FFFF, then ADD 0x1.
- Macro undefined -> out_acc=0x8000_0000, out_ovf=1.
- Macro defined -> out_acc=0x7FFF_FFFF, out_ovf=1.
REQ-032 The bench SHALL check subtraction: LOAD 6, SUB 3 -> out_acc=3, out_cout=1; then LOAD 3, SUB 8 -> out_acc=0xFFFF_FFFB, out_cout=0, out_ovf=0.
REQ-033 The bench SHALL check backpressure: hold out_ready=0 for 3 cycles with in_valid=1 and a pending result.
- Expect in_ready=0 and outputs unchanged for those cycles.
- Raising out_ready SHALL accept the next command in the same cycle, with its result one cycle later and out_valid continuously high.
REQ-034 The bench SHALL check reset mid-operation: assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_acc=0; no stale result appears afterwards.
